// File: rtl/ram_burst_reader.sv
// ram_burst_reader
// Read-side burst engine for a 256 x 32 dual-port block RAM. It accepts a
// command (start address, word count) and drives the RAM read port. Read data
// arrives one cycle after the address. The words are streamed out on a
// valid/ready interface that supports backpressure.
//
// Ports:
//   clk_i, rst_i        single clock, synchronous active-high reset
//   cmd_valid_i/ready_o command handshake
//   cmd_addr_i          first RAM address of the burst
//   cmd_len_i           word count; values above 2^ADDR_W saturate to 2^ADDR_W
//   ram_rd_en_o         RAM read enable, held high for the whole burst
//   ram_rd_addr_o       RAM read address
//   ram_rd_data_i       RAM read data, valid one cycle after the address
//   m_valid_o/ready_i   output stream handshake
//   m_data_o, m_last_o  output word, and a flag marking the final word
//   busy_o              burst in progress
//   done_o              one-cycle pulse when the burst completes
module ram_burst_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [DATA_W-1:0] ram_rd_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   addr_hold;
  logic [LEN_W-1:0]    remaining;
  logic [LEN_W-1:0]    sat_len;
  logic                inflight;
  logic                inflight_last;
  logic [DATA_W-1:0]   fifo_data [2];
  logic [1:0]          fifo_last;
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          fifo_count;
  logic [2:0]          occupancy;
  logic                done_q;
  logic                accept;
  logic                issue;
  logic                pop;
  logic                head_last;

  assign cmd_ready_o   = (state == IDLE) && !rst_i;
  // The RAM tri-states its output while rd_en is low. Enable therefore stays
  // high for the whole burst, including the drain of the last read.
  assign ram_rd_en_o   = (state != IDLE);
  // Combinational so that the read is launched in the issue cycle itself. On
  // other cycles the address holds, and the re-reads are never captured.
  assign ram_rd_addr_o = issue ? cur_addr : addr_hold;
  assign m_valid_o     = (fifo_count != 2'd0);
  assign head_last     = fifo_last[rd_ptr];
  assign m_data_o      = m_valid_o ? fifo_data[rd_ptr] : '0;
  assign m_last_o      = m_valid_o && head_last;
  assign busy_o        = (state != IDLE);
  assign done_o        = done_q;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    accept    = cmd_valid_i && cmd_ready_o;
    sat_len   = (cmd_len_i > MAX_LEN) ? MAX_LEN : cmd_len_i;
    pop       = m_valid_o && m_ready_i;
    occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    // Buffered words plus the word in flight, minus this cycle's pop, must
    // leave room in the 2-entry FIFO for the word that is issued now.
    issue     = (state == READ) && (remaining != '0) &&
                (occupancy <= ({2'b00, pop} + 3'd1));
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (sat_len != '0)) state_nxt = READ;
      READ:    if (issue && (remaining == LEN_W'(1))) state_nxt = DRAIN;
      DRAIN:   if (pop && head_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then sees the pre-edge values of the others, with no dependence on the
  // order of the statements.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cur_addr      <= '0;
      addr_hold     <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_last     <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_count    <= '0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_nxt;
      addr_hold     <= ram_rd_addr_o;
      inflight      <= issue;
      inflight_last <= issue && (remaining == LEN_W'(1));
      done_q        <= (accept && (sat_len == '0)) ||
                       ((state == DRAIN) && pop && head_last);

      if (accept) begin
        cur_addr  <= cmd_addr_i;
        remaining <= sat_len;
      end else if (issue) begin
        cur_addr  <= cur_addr + ADDR_W'(1);   // wraps naturally at 2^ADDR_W
        remaining <= remaining - LEN_W'(1);
      end

      if (inflight) begin
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // NOTE: the FIFO data storage is not reset. Reset empties the FIFO through
  // fifo_count, and m_data_o is gated by m_valid_o, so stale contents are
  // never visible.
  always_ff @(posedge clk_i) begin
    if (!rst_i && inflight) fifo_data[wr_ptr] <= ram_rd_data_i;
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader
// Directed testbench for ram_burst_reader. A behavioural 256 x 32 RAM holds
// bram[i] = i. Expected words are pushed to a scoreboard queue when a command
// is driven, and popped by a monitor on every output handshake.
module tb_ram_burst_reader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 9;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [LEN_W-1:0]  cmd_len_i;
  logic              ram_rd_en_o;
  logic [ADDR_W-1:0] ram_rd_addr_o;
  wire  [DATA_W-1:0] ram_rd_data_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DATA_W-1:0] m_data_o;
  logic              m_last_o;
  logic              busy_o;
  logic              done_o;

  always #5 clk_i = ~clk_i;

  ram_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_len_i     (cmd_len_i),
    .ram_rd_en_o   (ram_rd_en_o),
    .ram_rd_addr_o (ram_rd_addr_o),
    .ram_rd_data_i (ram_rd_data_i),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .m_data_o      (m_data_o),
    .m_last_o      (m_last_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  // RAM model: one-cycle read latency. The output is unknown while rd_en was
  // low, which stands in for the tri-stated bus.
  logic [DATA_W-1:0] bram [256];
  logic [DATA_W-1:0] ram_q;
  logic              ram_en_q = 1'b0;

  initial for (int i = 0; i < 256; i++) bram[i] = DATA_W'(i);

  always @(posedge clk_i) begin
    ram_en_q <= ram_rd_en_o;
    if (ram_rd_en_o) ram_q <= bram[ram_rd_addr_o];
  end
  assign ram_rd_data_i = ram_en_q ? ram_q : 'x;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t sb[$];
  int   rx_cnt   = 0;
  int   done_cnt = 0;

  task automatic push_burst(input logic [ADDR_W-1:0] addr, input int len);
    int   n;
    exp_t e;
    logic [ADDR_W-1:0] a;
    n = (len > 256) ? 256 : len;
    for (int i = 0; i < n; i++) begin
      a      = addr + ADDR_W'(i);
      e.data = DATA_W'(a);
      e.last = (i == n - 1);
      sb.push_back(e);
    end
  endtask

  // Output monitor: the scoreboard compare, stall stability and the read
  // enable held during a burst.
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;

  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_valid_o, 1);
        check("stall_data",  m_data_o,  prev_data);
        check("stall_last",  m_last_o,  prev_last);
      end
      if (busy_o) check("rd_en_busy", ram_rd_en_o, 1);
      if (done_o) done_cnt++;
      if (m_valid_o && m_ready_i) begin
        exp_t e;
        logic nonempty;
        nonempty = (sb.size() != 0);
        check("unexpected_word", nonempty, 1);
        if (nonempty) begin
          e = sb.pop_front();
          check("word_data", m_data_o, e.data);
          check("word_last", m_last_o, e.last);
        end
        rx_cnt++;
      end
      prev_stall <= m_valid_o && !m_ready_i;
      prev_data  <= m_data_o;
      prev_last  <= m_last_o;
    end
  end

  // Called just after a rising edge. Returns just after the accepting edge.
  task automatic issue_cmd(input logic [ADDR_W-1:0] addr, input int len);
    logic got;
    got = 1'b0;
    push_burst(addr, len);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = addr;
    cmd_len_i   = LEN_W'(len);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_i);
      if (cmd_ready_o) begin
        got = 1'b1;
        break;
      end
    end
    check("cmd_accept", got, 1);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int       rx0;
    int       d0;
    int       cnt;
    logic     seen;
    logic [3:0] pat;

    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_len_i   = '0;
    m_ready_i   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_cmd_ready", cmd_ready_o,   0);
    check("rst_valid",     m_valid_o,     0);
    check("rst_data",      m_data_o,      0);
    check("rst_last",      m_last_o,      0);
    check("rst_busy",      busy_o,        0);
    check("rst_done",      done_o,        0);
    check("rst_rd_en",     ram_rd_en_o,   0);
    check("rst_rd_addr",   ram_rd_addr_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rel_cmd_ready", cmd_ready_o, 1);

    // Basic burst: cycle-exact latency, last flag and done timing
    @(posedge clk_i); #1;
    push_burst(8'h10, 4);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = 8'h10;
    cmd_len_i   = 9'd4;
    @(negedge clk_i);
    check("t1_cmd_ready", cmd_ready_o, 1);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      check("t1_valid", m_valid_o, (k >= 3 && k <= 6));
      check("t1_done",  done_o,    (k == 7));
      if (k == 1) check("t1_rd_addr", ram_rd_addr_o, 8'h10);
      if (k == 6) check("t1_last",    m_last_o,      1);
    end
    @(posedge clk_i); #1;
    check("t1_sb_empty", sb.size(), 0);

    // Address wrap 0xFE -> 0x01
    issue_cmd(8'hFE, 4);
    wait_done("wrap_done", 20);
    check("wrap_sb_empty", sb.size(), 0);

    // Backpressure with a pseudo-random ready pattern
    rx0 = rx_cnt;
    pat = 4'b1001;
    issue_cmd(8'h30, 8);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      m_ready_i = pat[i % 4] ^ ($urandom_range(0, 3) == 0);
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
    end
    check("bp_done", seen, 1);
    @(posedge clk_i); #1;
    m_ready_i = 1'b1;
    check("bp_count",    rx_cnt - rx0, 8);
    check("bp_sb_empty", sb.size(),    0);

    // Zero length: done pulse only, no RAM activity
    rx0 = rx_cnt;
    issue_cmd(8'h55, 0);
    @(negedge clk_i);
    check("len0_done",  done_o,      1);
    check("len0_rd_en", ram_rd_en_o, 0);
    check("len0_valid", m_valid_o,   0);
    check("len0_busy",  busy_o,      0);
    @(negedge clk_i);
    check("len0_done_off", done_o,       0);
    check("len0_rx",       rx_cnt - rx0, 0);
    @(posedge clk_i); #1;

    // Oversized length saturates to 256 words
    rx0 = rx_cnt;
    issue_cmd(8'h00, 300);
    wait_done("sat_done", 400);
    check("sat_count",    rx_cnt - rx0, 256);
    check("sat_sb_empty", sb.size(),    0);

    // Reset mid-burst after three words
    issue_cmd(8'h80, 10);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (m_valid_o && m_ready_i) cnt++;
      if (cnt == 3) break;
    end
    check("abort_three_words", cnt, 3);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    d0    = done_cnt;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    sb.delete();
    @(negedge clk_i);
    check("abort_valid", m_valid_o,   0);
    check("abort_data",  m_data_o,    0);
    check("abort_last",  m_last_o,    0);
    check("abort_busy",  busy_o,      0);
    check("abort_rd_en", ram_rd_en_o, 0);
    check("abort_done",  done_o,      0);
    @(posedge clk_i); #1;
    rx0 = rx_cnt;
    issue_cmd(8'h40, 2);
    wait_done("post_abort_done", 20);
    check("post_abort_done_cnt", done_cnt - d0, 1);
    check("post_abort_count",    rx_cnt - rx0,  2);
    check("post_abort_sb_empty", sb.size(),     0);

    // Command held valid through a burst, accepted in the done cycle
    issue_cmd(8'h60, 3);
    push_burst(8'h20, 2);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = 8'h20;
    cmd_len_i   = 9'd2;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        check("held_ready_done", cmd_ready_o, 1);
        seen = 1'b1;
        break;
      end
      check("held_ready_busy", cmd_ready_o, 0);
    end
    check("held_done_seen", seen, 1);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    check("held_second_busy", busy_o, 1);
    wait_done("held_second_done", 20);
    check("held_sb_empty", sb.size(), 0);

    repeat (2) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read-side burst engine for the 256 x 32 dual-port block RAM. It accepts a command (start address, word count), drives the RAM read port (`rd_en`/`rd_addr` in, `rd_data` out one cycle later), and streams the words out on a valid/ready interface with backpressure. It sits between the RAM read port and any downstream consumer, single clock domain (the RAM read clock).

## Interface
- `ADDR_W`, 8, RAM address width (depth = 2^ADDR_W)
- `DATA_W`, 32, RAM word width
- `LEN_W`, ADDR_W+1, burst-length field width (max burst = 2^ADDR_W)
- `clk_i` in 1: single clock; all logic on rising edge
- `rst_i` in 1: reset, synchronous, active-high
- `cmd_valid_i` in 1: command offered
- `cmd_ready_o` out 1: engine idle and can accept a command
- `cmd_addr_i` in ADDR_W: first RAM address of burst
- `cmd_len_i` in LEN_W: word count, 0..256; values >256 saturate to 256
- `ram_rd_en_o` out 1: to RAM `rd_en_i`
- `ram_rd_addr_o` out ADDR_W: to RAM `rd_addr_i`
- `ram_rd_data_i` in DATA_W: from RAM `rd_data_o`
- `m_valid_o` out 1: output word valid
- `m_ready_i` in 1: downstream accepts word
- `m_data_o` out DATA_W: output word
- `m_last_o` out 1: marks final word of burst, qualified by `m_valid_o`
- `busy_o` out 1: burst in progress (state != IDLE)
- `done_o` out 1: one-cycle pulse at burst completion

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: `cmd_ready_o`=1. On `cmd_valid_i && cmd_ready_o`, latch `cur_addr`=`cmd_addr_i` and `remaining`=saturated length. If length is 0, pulse `done_o` the next cycle and stay IDLE. Otherwise go to READ.
- RAM rule: RAM output is tri-stated whenever its `rd_en` is low. So `ram_rd_en_o` is held 1 for every cycle in READ and DRAIN, and is 0 in IDLE.
- Issue: in READ, issue is asserted when `remaining != 0` and `(fifo_count + inflight - pop) <= 1`, where `pop = m_valid_o && m_ready_i`. On an issue cycle:
  - `ram_rd_addr_o` = `cur_addr`
  - `cur_addr` increments and wraps from 255 to 0
  - `remaining` decrements
  - `inflight` is set for the next cycle
- `ram_rd_addr_o` holds its last value on non-issue cycles. Re-reads caused by holding are ignored.
- Capture: on the cycle after an issue (`inflight`=1), push `ram_rd_data_i` into a 2-entry output FIFO. Push and pop in the same cycle are legal. The FIFO never overflows by construction.
- Output: `m_data_o`/`m_valid_o` come from the FIFO head. `m_last_o` is 1 when the head is the final word of the burst.
- READ goes to DRAIN on the issue cycle that makes `remaining`=0.
- DRAIN goes to IDLE when the last word is popped. `done_o` pulses the cycle after that pop.
- `m_data_o`, `m_valid_o` and `m_last_o` are stable while `m_valid_o && !m_ready_i`.
- New commands are not accepted until back in IDLE. `cmd_ready_o`=0 in READ and DRAIN.

## Timing
- Reset (sync, evaluated at clock edge):
  - state=IDLE, FIFO emptied, `inflight`=0
  - `ram_rd_en_o`=0, `ram_rd_addr_o`=0, `m_valid_o`=0, `m_last_o`=0, `m_data_o`=0, `busy_o`=0, `done_o`=0
  - `cmd_ready_o`=0 while `rst_i`=1, and 1 from the first cycle after release
- Reset mid-burst: aborts immediately, discards FIFO and in-flight data, no `done_o`.
- Command accepted at edge T:
  - cycle T+1: READ, first issue
  - cycle T+2: capture
  - cycle T+3: first `m_valid_o`
- First-word latency is 3 cycles from acceptance.
- Throughput with `m_ready_i` held 1: one word per cycle, N-word burst has last handshake at T+2+N, and `done_o` is high at T+3+N.
- Back-to-back: the next command can be accepted in the `done_o` cycle (IDLE). There is no overlap of bursts.
- Backpressure: at most 2 words buffered plus 1 in flight. Issue stalls within the same cycle as the stall condition. No data loss or duplication under any `m_ready_i` pattern.

## Test plan
- Reset, then cmd addr=0x10, len=4, RAM preloaded with bram[i]=i, `m_ready_i`=1:
  - data 0x10..0x13 on consecutive cycles starting at T+3
  - `m_last_o` on 0x13
  - `done_o` at T+7
- Wrap: addr=0xFE, len=4 gives data 0xFE, 0xFF, 0x00, 0x01 in order.
- Backpressure: len=8, `m_ready_i` toggling 1,0,0,1 pseudo-randomly:
  - exactly 8 words, in order, no duplicates
  - outputs stable while stalled
  - `ram_rd_en_o`=1 throughout the burst
- len=0: no RAM issue, no `m_valid_o`, `done_o` pulse one cycle after acceptance. len=300 transfers exactly 256 words.
- Reset asserted mid-burst (after 3 of 10 words), then a new cmd addr=0x40, len=2:
  - outputs zero the cycle after reset
  - no `done_o` for the aborted burst
  - only 0x40, 0x41 delivered
- `cmd_valid_i` held during a burst: `cmd_ready_o`=0 until IDLE, then the second command is accepted in the `done_o` cycle.
